fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder. Owns the PC register and issues word fetches over a req/ack instruction-memory handshake.
- Presents the fetched instruction plus its PC and PC+4 to decode/execute. On retire, computes the next PC from the decoder's pc_src, the branch condition, the immediate, the jump address and the register-file value.
- Multi-cycle, handshake-driven: one instruction in flight at a time. There is no speculation and no delay slot.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_next_pc_calc.sv | 35 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared opcode/width definitions for the fetch stage and its next-PC helper.
package fetch_unit_pkg;

    localparam int unsigned W_CPU    = 32;
    localparam int unsigned W_IMM    = 16;
    localparam int unsigned W_JADDR  = 26;
    localparam int unsigned W_PC_SRC = 2;

    // Next-PC source selected by decode.
    typedef enum logic [W_PC_SRC-1:0] {
        PC_SRC_NEXT = 2'd0,
        PC_SRC_BRCH = 2'd1,
        PC_SRC_JUMP = 2'd2,
        PC_SRC_REGF = 2'd3
    } pc_src_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_REQ    = 2'd1,
        FS_VALID  = 2'd2,
        FS_HALTED = 2'd3
    } fetch_state_e;

    // Sign-extended, word-scaled branch offset.
    function automatic logic [W_CPU-1:0] branch_offset(input logic [W_IMM-1:0] imm);
        return {{(W_CPU - W_IMM - 2){imm[W_IMM-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [W_CPU-1:0]   pc_plus4,
    input  pc_src_e            pc_src,
    input  logic               check_zero,
    input  logic               alu_zero,
    input  logic [W_IMM-1:0]   imm,
    input  logic [W_JADDR-1:0] addr,
    input  logic [W_CPU-1:0]   reg_data,
    output logic [W_CPU-1:0]   next_pc,
    output logic               misalign_hit
);

    logic taken;

    // Select the retire target; all adds wrap at W_CPU bits.
    always_comb begin
        next_pc      = pc_plus4;
        misalign_hit = 1'b0;
        taken        = check_zero ? alu_zero : ~alu_zero;
        case (pc_src)
            PC_SRC_NEXT: next_pc = pc_plus4;
            PC_SRC_BRCH: next_pc = taken ? (pc_plus4 + branch_offset(imm)) : pc_plus4;
            PC_SRC_JUMP: next_pc = {pc_plus4[W_CPU-1:W_CPU-4], addr, 2'b00};
            PC_SRC_REGF: begin
                next_pc      = {reg_data[W_CPU-1:2], 2'b00};
                misalign_hit = (reg_data[1:0] != 2'b00);
            end
            default:     next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack fetch FSM and instruction latch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [W_CPU-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [W_CPU-1:0]    imem_addr,
    input  logic                imem_ack,
    input  logic [W_CPU-1:0]    imem_rdata,
    output logic [W_CPU-1:0]    inst,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [W_CPU-1:0]    pc,
    output logic [W_CPU-1:0]    pc_plus4,
    input  logic [W_PC_SRC-1:0] pc_src,
    input  logic                check_zero,
    input  logic                alu_zero,
    input  logic [W_IMM-1:0]    imm,
    input  logic [W_JADDR-1:0]  addr,
    input  logic [W_CPU-1:0]    reg_data,
    input  logic                halt,
    output logic                misalign
);

    fetch_state_e     state_q,      state_d;
    logic [W_CPU-1:0] pc_q,         pc_d;
    logic [W_CPU-1:0] pc_plus4_q,   pc_plus4_d;
    logic [W_CPU-1:0] inst_q,       inst_d;
    logic             inst_valid_q, inst_valid_d;
    logic             imem_req_q,   imem_req_d;
    logic             misalign_q,   misalign_d;

    logic [W_CPU-1:0] next_pc;
    logic             misalign_hit;

    next_pc_calc u_next_pc_calc (
        .pc_plus4     (pc_plus4_q),
        .pc_src       (pc_src_e'(pc_src)),
        .check_zero   (check_zero),
        .alu_zero     (alu_zero),
        .imm          (imm),
        .addr         (addr),
        .reg_data     (reg_data),
        .next_pc      (next_pc),
        .misalign_hit (misalign_hit)
    );

    // Next-state and next-output logic; imem_req is registered so it tracks the REQ state exactly.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        misalign_d   = misalign_q;
        case (state_q)
            FS_BOOT: begin
                state_d    = FS_REQ;
                imem_req_d = 1'b1;
            end
            FS_REQ: begin
                if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    imem_req_d   = 1'b0;
                    state_d      = FS_VALID;
                end
            end
            FS_VALID: begin
                if (inst_ready) begin
                    pc_d         = next_pc;
                    pc_plus4_d   = next_pc + W_CPU'(4);
                    inst_valid_d = 1'b0;
                    if (misalign_hit) begin
                        misalign_d = 1'b1;
                    end
                    if (halt) begin
                        state_d = FS_HALTED;
                    end else begin
                        state_d    = FS_REQ;
                        imem_req_d = 1'b1;
                    end
                end
            end
            FS_HALTED: begin
                imem_req_d = 1'b0;
            end
            default: begin
                state_d    = FS_BOOT;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FS_BOOT;
            pc_q         <= RESET_PC;
            pc_plus4_q   <= RESET_PC + W_CPU'(4);
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized retire traffic.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_src;
    logic        check_zero;
    logic        alu_zero;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] reg_data;
    logic        halt;
    logic        misalign;

    int n_chk  = 0;
    int n_pass = 0;
    int overlap = 0;
    logic [31:0] model_pc;
    logic        model_mis;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc(pc), .pc_plus4(pc_plus4),
        .pc_src(pc_src), .check_zero(check_zero), .alu_zero(alu_zero),
        .imm(imm), .addr(addr), .reg_data(reg_data), .halt(halt),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // valid and request must never be high together
    always @(negedge clk) if (rst_n && imem_req && inst_valid) overlap++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference next-PC from the instruction-set rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] src,
        input bit cz, input bit az, input logic [15:0] im, input logic [25:0] ad, input logic [31:0] rd);
        logic [31:0] seq;
        int off;
        seq = cur + 32'd4;
        off = int'($signed(im)) * 4;
        if (src == PC_SRC_BRCH) return ((cz ? az : !az) ? seq + 32'(off) : seq);
        if (src == PC_SRC_JUMP) return (seq & 32'hF000_0000) | (32'(ad) << 2);
        if (src == PC_SRC_REGF) return rd & 32'hFFFF_FFFC;
        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch: dly cycles without ack, then ack with data. Returns the request address.
    task automatic fetch(input int dly, input logic [31:0] data, input bit noise,
                         output logic [31:0] a, output bit st);
        a  = 'x;
        st = 1'b1;
        for (int i = 0; i < 50 && !imem_req; i++) tick();
        if (imem_req) begin
            a = imem_addr;
            for (int i = 0; i < dly; i++) begin
                imem_rdata = $urandom;
                if (noise) begin
                    inst_ready = 1'($urandom);
                    halt       = 1'($urandom);
                end
                tick();
                if (imem_req !== 1'b1 || imem_addr !== a) st = 1'b0;
            end
            imem_ack   = 1'b1;
            imem_rdata = data;
            tick();
            imem_ack   = 1'b0;
            inst_ready = 1'b0;
            halt       = 1'b0;
            imem_rdata = $urandom;
        end
    endtask

    // Retire the valid instruction with the given next-PC inputs.
    task automatic retire(input logic [1:0] src, input bit cz, input bit az, input logic [15:0] im,
                          input logic [25:0] ad, input logic [31:0] rd, input bit h);
        for (int i = 0; i < 50 && !inst_valid; i++) tick();
        pc_src = src; check_zero = cz; alu_zero = az; imm = im; addr = ad; reg_data = rd; halt = h;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        halt       = 1'b0;
    endtask

    task automatic step(input logic [1:0] src, input bit cz, input bit az, input logic [15:0] im,
                        input logic [25:0] ad, input logic [31:0] rd, input bit h, output logic [31:0] a);
        bit st;
        fetch(1, $urandom, 1'b0, a, st);
        retire(src, cz, az, im, ad, rd, h);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 0; imem_rdata = 0; inst_ready = 0; pc_src = 0;
        check_zero = 0; alu_zero = 0; imm = 0; addr = 0; reg_data = 0; halt = 0;
        repeat (3) tick();
        n_chk++; if (imem_req !== 1'b0)      $display("FAIL rst_req: got %b want 0", imem_req);          else n_pass++;
        n_chk++; if (inst_valid !== 1'b0)    $display("FAIL rst_valid: got %b want 0", inst_valid);      else n_pass++;
        n_chk++; if (pc !== RST_PC)          $display("FAIL rst_pc: got %h want %h", pc, RST_PC);        else n_pass++;
        n_chk++; if (pc_plus4 !== RST_PC+4)  $display("FAIL rst_pc4: got %h want %h", pc_plus4, RST_PC+4); else n_pass++;
        n_chk++; if (inst !== 32'h0)         $display("FAIL rst_inst: got %h want 0", inst);             else n_pass++;
        n_chk++; if (imem_addr !== RST_PC)   $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); else n_pass++;
        n_chk++; if (misalign !== 1'b0)      $display("FAIL rst_mis: got %b want 0", misalign);          else n_pass++;
        rst_n = 1'b1;
        n_chk++; if (imem_req !== 1'b0)      $display("FAIL boot_req: got %b want 0", imem_req);         else n_pass++;
        tick();
        n_chk++; if (imem_req !== 1'b1)      $display("FAIL boot_to_req: got %b want 1", imem_req);      else n_pass++;
        model_pc = RST_PC; model_mis = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            step(PC_SRC_NEXT, 0, 0, 0, 0, 0, 0, a);
            n_chk++; if (a !== 32'(i * 4)) $display("FAIL seq_addr%0d: got %h want %h", i, a, 32'(i * 4)); else n_pass++;
        end
        n_chk++; if (overlap !== 0) $display("FAIL seq_overlap: got %0d want 0", overlap); else n_pass++;
    endtask

    task automatic test_branch();
        logic [31:0] a;
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'h10, 0, a);
        n_chk++; if (a !== 32'hC) $display("FAIL br_start: got %h want 0000000c", a); else n_pass++;
        step(PC_SRC_BRCH, 1, 1, 16'hFFFC, 0, 0, 0, a);
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'h10, 0, a);
        n_chk++; if (a !== 32'h04) $display("FAIL beq_taken: got %h want 00000004", a); else n_pass++;
        step(PC_SRC_BRCH, 1, 0, 16'hFFFC, 0, 0, 0, a);
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'h10, 0, a);
        n_chk++; if (a !== 32'h14) $display("FAIL beq_not_taken: got %h want 00000014", a); else n_pass++;
        step(PC_SRC_BRCH, 0, 0, 16'hFFFC, 0, 0, 0, a);
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'h10, 0, a);
        n_chk++; if (a !== 32'h04) $display("FAIL bne_taken: got %h want 00000004", a); else n_pass++;
        step(PC_SRC_BRCH, 1, 1, 16'hFFFF, 0, 0, 0, a);
        step(PC_SRC_NEXT, 0, 0, 0, 0, 0, 0, a);
        n_chk++; if (a !== 32'h10) $display("FAIL self_loop: got %h want 00000010", a); else n_pass++;
    endtask

    task automatic test_jump();
        logic [31:0] a;
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, a);
        n_chk++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h want 00000000", pc_plus4); else n_pass++;
        step(PC_SRC_NEXT, 0, 0, 0, 0, 0, 0, a);
        n_chk++; if (a !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h want fffffffc", a); else n_pass++;
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'h3000_0000, 0, a);
        n_chk++; if (a !== 32'h0) $display("FAIL wrap_zero: got %h want 00000000", a); else n_pass++;
        step(PC_SRC_JUMP, 0, 0, 0, 26'h000_0040, 0, 0, a);
        n_chk++; if (misalign !== 1'b0) $display("FAIL jr_aligned_mis: got %b want 0", misalign); else n_pass++;
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'h0000_0203, 0, a);
        n_chk++; if (a !== 32'h3000_0100) $display("FAIL j_target: got %h want 30000100", a); else n_pass++;
        n_chk++; if (misalign !== 1'b1) $display("FAIL jr_mis_set: got %b want 1", misalign); else n_pass++;
        step(PC_SRC_NEXT, 0, 0, 0, 0, 0, 0, a);
        n_chk++; if (a !== 32'h200) $display("FAIL jr_target: got %h want 00000200", a); else n_pass++;
        n_chk++; if (misalign !== 1'b1) $display("FAIL mis_sticky: got %b want 1", misalign); else n_pass++;
    endtask

    task automatic test_slow_ack();
        logic [31:0] a, d, pc0;
        bit st, hold_ok;
        d = $urandom;
        fetch(5, d, 1'b0, a, st);
        n_chk++; if (a !== 32'h204) $display("FAIL slow_addr: got %h want 00000204", a); else n_pass++;
        n_chk++; if (st !== 1'b1)   $display("FAIL slow_req_stable: got %b want 1", st); else n_pass++;
        n_chk++; if (inst !== d)    $display("FAIL slow_inst: got %h want %h", inst, d); else n_pass++;
        pc0 = pc;
        hold_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (inst !== d || pc !== 32'h204 || inst_valid !== 1'b1) hold_ok = 1'b0;
        end
        n_chk++; if (hold_ok !== 1'b1) $display("FAIL slow_hold: got %b want 1 (pc %h inst %h)", hold_ok, pc, inst); else n_pass++;
        retire(PC_SRC_NEXT, 0, 0, 0, 0, 0, 0);
        model_pc = pc0 + 32'd4;
        model_mis = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd;
        logic [15:0] im;
        logic [25:0] ad;
        logic [1:0]  src;
        bit st, cz, az;
        for (int k = 0; k < 40; k++) begin
            d = $urandom;
            fetch($urandom_range(1, 4), d, 1'b1, a, st);
            n_chk++; if (a !== model_pc)          $display("FAIL rnd_addr%0d: got %h want %h", k, a, model_pc); else n_pass++;
            n_chk++; if (pc_plus4 !== model_pc+4) $display("FAIL rnd_pc4_%0d: got %h want %h", k, pc_plus4, model_pc + 32'd4); else n_pass++;
            repeat ($urandom_range(0, 2)) begin
                imem_ack = 1'($urandom); imem_rdata = $urandom;
                tick();
            end
            imem_ack = 1'b0;
            n_chk++; if (inst !== d) $display("FAIL rnd_inst%0d: got %h want %h", k, inst, d); else n_pass++;
            src = 2'($urandom_range(0, 3)); cz = 1'($urandom); az = 1'($urandom);
            im = 16'($urandom); ad = 26'($urandom); rd = $urandom;
            if ($urandom_range(0, 3) != 0) rd[1:0] = 2'b00;
            retire(src, cz, az, im, ad, rd, 1'b0);
            if (src == PC_SRC_REGF && rd[1:0] != 2'b00) model_mis = 1'b1;
            model_pc = model_next(model_pc, src, cz, az, im, ad, rd);
            n_chk++; if (pc !== model_pc)        $display("FAIL rnd_pc%0d: got %h want %h", k, pc, model_pc); else n_pass++;
            n_chk++; if (misalign !== model_mis) $display("FAIL rnd_mis%0d: got %b want %b", k, misalign, model_mis); else n_pass++;
        end
        n_chk++; if (overlap !== 0) $display("FAIL rnd_overlap: got %0d want 0", overlap); else n_pass++;
    endtask

    task automatic test_halt();
        logic [31:0] a, d;
        bit st;
        int reqs;
        step(PC_SRC_REGF, 0, 0, 0, 0, 32'h20, 0, a);
        d = $urandom;
        fetch(1, d, 1'b1, a, st);
        n_chk++; if (a !== 32'h20) $display("FAIL halt_addr: got %h want 00000020", a); else n_pass++;
        retire(PC_SRC_NEXT, 0, 0, 0, 0, 0, 1'b1);
        n_chk++; if (pc !== 32'h24)       $display("FAIL halt_pc: got %h want 00000024", pc); else n_pass++;
        n_chk++; if (pc_plus4 !== 32'h28) $display("FAIL halt_pc4: got %h want 00000028", pc_plus4); else n_pass++;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom); imem_rdata = $urandom; inst_ready = 1'($urandom);
            pc_src = 2'($urandom); reg_data = $urandom;
            tick();
            if (imem_req !== 1'b0) reqs++;
        end
        imem_ack = 1'b0; inst_ready = 1'b0;
        n_chk++; if (reqs !== 0)          $display("FAIL halt_no_req: got %0d want 0", reqs); else n_pass++;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL halt_valid: got %b want 0", inst_valid); else n_pass++;
        n_chk++; if (pc !== 32'h24)       $display("FAIL halt_pc_hold: got %h want 00000024", pc); else n_pass++;
        n_chk++; if (inst !== d)          $display("FAIL halt_inst_hold: got %h want %h", inst, d); else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] a;
        bit st;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        step(PC_SRC_NEXT, 0, 0, 0, 0, 0, 0, a);
        n_chk++; if (imem_req !== 1'b1) $display("FAIL mid_req_pre: got %b want 1", imem_req); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL mid_req_drop: got %b want 0", imem_req); else n_pass++;
        n_chk++; if (pc !== RST_PC)     $display("FAIL mid_pc: got %h want %h", pc, RST_PC); else n_pass++;
        n_chk++; if (misalign !== 1'b0) $display("FAIL mid_mis: got %b want 0", misalign); else n_pass++;
        imem_ack = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL mid_ack_ignored: got %b want 0", inst_valid); else n_pass++;
        n_chk++; if (imem_req !== 1'b1)   $display("FAIL mid_boot_req: got %b want 1", imem_req); else n_pass++;
        fetch(1, $urandom, 1'b0, a, st);
        n_chk++; if (a !== RST_PC) $display("FAIL mid_refetch: got %h want %h", a, RST_PC); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_slow_ack();
        test_random();
        test_halt();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
